// File: rtl/x25519_freeze.sv
// x25519_freeze: final canonical reduction of a 264-bit partially reduced
// value into [0, p-1] with p = 2^255-19.  The fold of the top nine bits and
// the trial subtraction of p both run 32 bits per cycle, least significant
// word first.  A one-bit carry/borrow register links consecutive words, so
// the design has no full-width adder or subtractor.
//
// Timeline for a request accepted at edge N:
//   N          capture a, busy rises
//   N+1..N+8   FOLD: build v = a[254:0] + 19*a[263:255], one word per edge
//   N+9..N+16  SUB : build t = v - p, one word per edge, leaving v intact
//   N+16       out = borrow ? v : t, out_valid pulses, busy falls
module x25519_freeze (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [263:0] a,
  output logic         busy,
  output logic         out_valid,
  output logic [255:0] out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FOLD = 2'd1,
    SUB  = 2'd2
  } state_t;

  state_t       state;
  logic [2:0]   idx;      // word currently being processed
  logic         carry;    // carry in FOLD, borrow in SUB
  logic [8:0]   hi;       // a[263:255], the part folded back in with weight 19
  logic [255:0] v_w;      // v, assembled / rotated one word per edge
  logic [255:0] t_w;      // v - p, assembled one word per edge

  // 19*h without a general multiplier: 16h + 2h + h.  Max 19*511 = 9709.
  function automatic logic [13:0] mul19(input logic [8:0] h);
    logic [13:0] hx;
    hx = {5'b0, h};
    return (hx << 4) + (hx << 1) + hx;
  endfunction

  // 32-bit word i of p = 2^255-19.
  function automatic logic [31:0] p_word(input logic [2:0] i);
    case (i)
      3'd0:    return 32'hFFFF_FFED;
      3'd7:    return 32'h7FFF_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  logic [13:0] fold_add;
  logic [32:0] fold_sum;
  logic [32:0] sub_diff;
  logic [255:0] v_rot;

  // The folded-in 19*hi enters only at word 0; higher words just ripple carry.
  assign fold_add = (idx == 3'd0) ? mul19(hi) : 14'd0;
  assign fold_sum = {1'b0, v_w[31:0]} + {19'b0, fold_add} + {32'b0, carry};
  // Bit 32 of the difference is the borrow out of this word.
  assign sub_diff = {1'b0, v_w[31:0]} - {1'b0, p_word(idx)} - {32'b0, carry};
  // Rotating v by one word per SUB edge returns it to its original order
  // after the eighth word, so v is never lost while t is being built.
  assign v_rot    = {v_w[31:0], v_w[255:32]};

  // Control FSM and word-serial datapath; reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 3'd0;
      carry     <= 1'b0;
      hi        <= 9'd0;
      v_w       <= '0;
      t_w       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            // Bit 255 is dropped here; it belongs to hi and is folded back.
            v_w   <= {1'b0, a[254:0]};
            hi    <= a[263:255];
            t_w   <= '0;
            idx   <= 3'd0;
            carry <= 1'b0;
            busy  <= 1'b1;
            state <= FOLD;
          end
        end
        FOLD: begin
          // New word enters at the top; after eight edges v sits in order.
          v_w   <= {fold_sum[31:0], v_w[255:32]};
          carry <= fold_sum[32];
          idx   <= idx + 3'd1;
          if (idx == 3'd7) begin
            // v < 2^255+9709 so the last word never carries out.
            carry <= 1'b0;
            state <= SUB;
          end
        end
        SUB: begin
          v_w   <= v_rot;
          t_w   <= {sub_diff[31:0], t_w[255:32]};
          carry <= sub_diff[32];
          idx   <= idx + 3'd1;
          if (idx == 3'd7) begin
            // Final borrow set means v < p, so v is already canonical.
            out       <= sub_diff[32] ? v_rot : {sub_diff[31:0], t_w[255:32]};
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
